// File: rtl/cpu_trace_emitter_pkg.sv
// Shared constants and character helpers for the CPU trace emitter.
package cpu_trace_emitter_pkg;

    localparam int unsigned MaxDec = 9999;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'b0000, n};
        end
        return 8'h57 + {4'b0000, n};
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'b0000, n};
    endfunction

    // Significant digit count of a 4-digit BCD value; zero still shows one digit.
    function automatic logic [2:0] bcd_ndig(input logic [15:0] b);
        if (b[15:12] != 4'd0) begin
            return 3'd4;
        end else if (b[11:8] != 4'd0) begin
            return 3'd3;
        end else if (b[7:4] != 4'd0) begin
            return 3'd2;
        end
        return 3'd1;
    endfunction

endpackage

// File: rtl/cpu_trace_defs.vh
// State encodings and ASCII constants shared by the trace emitter.
// The emit states from StCaret onward are numbered in output order, so "next field" is state + 1.
`ifndef CPU_TRACE_DEFS_VH
`define CPU_TRACE_DEFS_VH

localparam logic [3:0] StIdle  = 4'd0;
localparam logic [3:0] StConv  = 4'd1;
localparam logic [3:0] StCaret = 4'd2;
localparam logic [3:0] StTime  = 4'd3;
localparam logic [3:0] StAt    = 4'd4;
localparam logic [3:0] StPc    = 4'd5;
localparam logic [3:0] StColon = 4'd6;
localparam logic [3:0] StSp1   = 4'd7;
localparam logic [3:0] StTag   = 4'd8;
localparam logic [3:0] StField = 4'd9;
localparam logic [3:0] StSp2   = 4'd10;
localparam logic [3:0] StLt    = 4'd11;
localparam logic [3:0] StEq    = 4'd12;
localparam logic [3:0] StSp3   = 4'd13;
localparam logic [3:0] StData  = 4'd14;
localparam logic [3:0] StHash  = 4'd15;

localparam logic [7:0] CharCaret  = 8'h5e;
localparam logic [7:0] CharAt     = 8'h40;
localparam logic [7:0] CharColon  = 8'h3a;
localparam logic [7:0] CharDollar = 8'h24;
localparam logic [7:0] CharStar   = 8'h2a;
localparam logic [7:0] CharLt     = 8'h3c;
localparam logic [7:0] CharEq     = 8'h3d;
localparam logic [7:0] CharHash   = 8'h23;
localparam logic [7:0] CharSpace  = 8'h20;

`endif

// File: rtl/dec4_conv.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
module dec4_conv
    import cpu_trace_emitter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic [2:0]  ndig,
    output logic        done
);

    logic [15:0] bcd_q, bcd_d, adj;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = bcd_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        if (start) begin
            bcd_d = '0;
            bin_d = bin;
            cnt_d = 4'd14;
        end else if (cnt_q != 4'd0) begin
            {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
        end
    end

    // High during the cycle whose edge performs the final shift.
    assign done = (cnt_q == 4'd1);
    assign bcd  = bcd_q;
    assign ndig = bcd_ndig(bcd_q);

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one register/memory write record per handshake into an ASCII trace line.
module cpu_trace_emitter
    import cpu_trace_emitter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        kind,
    input  logic [13:0] time_val,
    input  logic [31:0] pc,
    input  logic [13:0] grf,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [7:0]  char_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last,
    output logic        clamped
);

    `include "cpu_trace_defs.vh"

    logic [3:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        kind_q, kind_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        clamped_q, clamped_d;

    logic        accept, fire, seg_end;
    logic [13:0] t_sat, g_sat;
    logic [15:0] t_bcd, g_bcd;
    logic [2:0]  t_ndig, g_ndig;
    logic        t_done, g_done;
    logic [1:0]  t_pos, g_pos;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q >= StCaret);
    assign last      = (state_q == StHash);
    assign clamped   = clamped_q;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    assign t_sat = (time_val > 14'(MaxDec)) ? 14'(MaxDec) : time_val;
    assign g_sat = (grf > 14'(MaxDec)) ? 14'(MaxDec) : grf;

    dec4_conv u_time_conv (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (t_sat),
        .bcd   (t_bcd),
        .ndig  (t_ndig),
        .done  (t_done)
    );

    dec4_conv u_grf_conv (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (g_sat),
        .bcd   (g_bcd),
        .ndig  (g_ndig),
        .done  (g_done)
    );

    always_comb begin
        case (state_q)
            StTime:  seg_end = (idx_q == t_ndig - 3'd1);
            StPc:    seg_end = (idx_q == 3'd7);
            StData:  seg_end = (idx_q == 3'd7);
            StField: seg_end = kind_q ? (idx_q == 3'd7) : (idx_q == g_ndig - 3'd1);
            default: seg_end = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        kind_d    = kind_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        data_d    = data_q;
        clamped_d = clamped_q;
        if (state_q == StIdle) begin
            if (accept) begin
                state_d   = StConv;
                idx_d     = 3'd0;
                kind_d    = kind;
                pc_d      = pc;
                addr_d    = addr;
                data_d    = data;
                clamped_d = (time_val > 14'(MaxDec)) || (grf > 14'(MaxDec));
            end
        end else if (state_q == StConv) begin
            if (t_done && g_done) begin
                state_d = StCaret;
            end
        end else if (fire) begin
            if (!seg_end) begin
                idx_d = idx_q + 3'd1;
            end else if (state_q == StHash) begin
                state_d   = StIdle;
                idx_d     = 3'd0;
                clamped_d = 1'b0;
            end else begin
                state_d = state_q + 4'd1;
                idx_d   = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            kind_q    <= 1'b0;
            pc_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            kind_q    <= kind_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            clamped_q <= clamped_d;
        end
    end

    // Decimal fields are printed most significant digit first.
    assign t_pos = 2'(t_ndig - 3'd1 - idx_q);
    assign g_pos = 2'(g_ndig - 3'd1 - idx_q);

    always_comb begin
        char_out = 8'h00;
        case (state_q)
            StCaret: char_out = CharCaret;
            StTime:  char_out = dec_char(t_bcd[{t_pos, 2'b00} +: 4]);
            StAt:    char_out = CharAt;
            StPc:    char_out = hex_char(pc_q[{~idx_q, 2'b00} +: 4]);
            StColon: char_out = CharColon;
            StSp1:   char_out = CharSpace;
            StTag:   char_out = kind_q ? CharStar : CharDollar;
            StField: char_out = kind_q ? hex_char(addr_q[{~idx_q, 2'b00} +: 4])
                                       : dec_char(g_bcd[{g_pos, 2'b00} +: 4]);
            StSp2:   char_out = CharSpace;
            StLt:    char_out = CharLt;
            StEq:    char_out = CharEq;
            StSp3:   char_out = CharSpace;
            StData:  char_out = hex_char(data_q[{~idx_q, 2'b00} +: 4]);
            StHash:  char_out = CharHash;
            default: char_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench: directed and random records against a string-formatting reference model.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        kind;
    logic [13:0] time_val;
    logic [31:0] pc;
    logic [13:0] grf;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  char_out;
    logic        out_valid;
    logic        out_ready;
    logic        last;
    logic        clamped;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_trace_emitter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .time_val  (time_val),
        .pc        (pc),
        .grf       (grf),
        .addr      (addr),
        .data      (data),
        .char_out  (char_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .clamped   (clamped)
    );

    task automatic check(input string tag, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got '%s' expected '%s'", tag, act, exp);
        end
    endtask

    function automatic string num(input int v);
        return $sformatf("%0d", v);
    endfunction

    // Reference: the trace line is just a formatted string of the saturated fields.
    function automatic string model(input bit k, input int t, input logic [31:0] p, input int g,
                                    input logic [31:0] a, input logic [31:0] d);
        int tc = (t > 9999) ? 9999 : t;
        int gc = (g > 9999) ? 9999 : g;
        if (!k) return $sformatf("^%0d@%08h: $%0d <= %08h#", tc, p, gc, d);
        return $sformatf("^%0d@%08h: *%08h <= %08h#", tc, p, a, d);
    endfunction

    task automatic drive_noise();
        in_valid = 1'b1;
        kind     = 1'($urandom);
        time_val = 14'($urandom);
        pc       = $urandom;
        grf      = 14'($urandom);
        addr     = $urandom;
        data     = $urandom;
    endtask

    // Enters and leaves at a negedge with the DUT idle.
    task automatic run_record(input string tag, input bit k, input int t, input logic [31:0] p,
                              input int g, input logic [31:0] a, input logic [31:0] d,
                              input bit bp, input bit ovl, output string got);
        string      exp_s;
        bit         exp_clamp, stalled, done;
        int         cyc, first, stall_bad, clamp_bad, ready_bad, last_bad, zero_bad;
        logic [7:0] prev;
        exp_s = model(k, t, p, g, a, d);
        exp_clamp = (t > 9999) || (g > 9999);
        got = "";
        check({tag, " in_ready before"}, num(int'(in_ready)), "1");
        check({tag, " clamped before"}, num(int'(clamped)), "0");
        in_valid = 1'b1;
        kind     = k;
        time_val = t[13:0];
        pc       = p;
        grf      = g[13:0];
        addr     = a;
        data     = d;
        @(posedge clk);
        first = -1; stalled = 0; done = 0; cyc = 0; prev = 8'h00;
        stall_bad = 0; clamp_bad = 0; ready_bad = 0; last_bad = 0; zero_bad = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ovl) drive_noise();
            else in_valid = 1'b0;
            if (in_ready) ready_bad++;
            if (stalled && (!out_valid || char_out != prev)) stall_bad++;
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (clamped != exp_clamp) clamp_bad++;
            end else if (char_out != 8'h00) begin
                zero_bad++;
            end
            if (last != (out_valid && char_out == 8'h23)) last_bad++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = out_valid && !out_ready;
            prev = char_out;
            if (out_valid && out_ready) begin
                got = {got, $sformatf("%c", char_out)};
                if (last) done = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " completed"}, num(int'(done)), "1");
        check({tag, " stream"}, got, exp_s);
        check({tag, " length"}, num(got.len()), num(exp_s.len()));
        check({tag, " first char cycle"}, num(first), "15");
        check({tag, " stall stability"}, num(stall_bad), "0");
        check({tag, " clamped flag"}, num(clamp_bad), "0");
        check({tag, " in_ready busy"}, num(ready_bad), "0");
        check({tag, " last with hash"}, num(last_bad), "0");
        check({tag, " idle char zero"}, num(zero_bad), "0");
    endtask

    initial begin
        string s1, s2;
        int    cnt, cyc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; kind = 1'b0;
        time_val = '0; pc = '0; grf = '0; addr = '0; data = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset out_valid", num(int'(out_valid)), "0");
        check("reset last", num(int'(last)), "0");
        check("reset char_out", num(int'(char_out)), "0");
        check("reset clamped", num(int'(clamped)), "0");
        check("reset in_ready", num(int'(in_ready)), "1");
        reset = 1'b0;

        run_record("reg", 0, 5, 32'h00003000, 31, 32'h0, 32'hdeadbeef, 0, 0, s1);
        check("reg literal", s1, "^5@00003000: $31 <= deadbeef#");
        run_record("mem", 1, 1234, 32'h00400010, 0, 32'h10008000, 32'h0, 0, 0, s2);
        check("mem literal", s2, "^1234@00400010: *10008000 <= 00000000#");
        run_record("zero", 0, 0, 32'h12345678, 0, 32'h0, 32'h0badf00d, 0, 0, s2);
        check("zero literal", s2, "^0@12345678: $0 <= 0badf00d#");
        run_record("clamp", 0, 12000, 32'habcdef01, 7, 32'h0, 32'h1, 0, 0, s2);
        run_record("after clamp", 1, 42, 32'h0, 3, 32'hffffffff, 32'h2, 0, 0, s2);
        run_record("backpressure", 0, 5, 32'h00003000, 31, 32'h0, 32'hdeadbeef, 1, 0, s2);
        check("backpressure vs ready", s2, s1);

        // Reset while the PC field is being emitted, with a competing offer present.
        in_valid = 1'b1; kind = 1'b0; time_val = 14'd12000; pc = 32'h00003000;
        grf = 14'd31; addr = '0; data = 32'hdeadbeef; out_ready = 1'b1;
        @(posedge clk);
        cnt = 0; cyc = 0;
        while (cnt < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (out_valid && out_ready) cnt++;
        end
        check("midreset reached pc", num(cnt), "6");
        @(negedge clk);
        reset = 1'b1;
        drive_noise();
        @(posedge clk);
        @(negedge clk);
        check("midreset out_valid", num(int'(out_valid)), "0");
        check("midreset in_ready", num(int'(in_ready)), "1");
        check("midreset char_out", num(int'(char_out)), "0");
        check("midreset clamped", num(int'(clamped)), "0");
        reset = 1'b0;
        in_valid = 1'b0;
        run_record("after reset", 0, 5, 32'h00003000, 31, 32'h0, 32'hdeadbeef, 0, 0, s2);

        run_record("overlap", 1, 77, 32'hcafe0000, 9, 32'h00000abc, 32'h55aa55aa, 0, 1, s2);
        run_record("post overlap", 0, 9999, 32'h1, 10000, 32'h0, 32'h3, 1, 1, s2);

        for (int i = 0; i < 15; i++) begin
            run_record($sformatf("rand%0d", i), 1'($urandom), int'($urandom_range(0, 16383)),
                       $urandom, int'($urandom_range(0, 16383)), $urandom, $urandom,
                       1'($urandom), 1'($urandom), s2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: record offered.
REQ-004 SHALL have port in_ready, output, 1 bit: record accepted this cycle if in_valid is also high.
REQ-005 SHALL have port kind, input, 1 bit: 0 = register record, 1 = memory record.
REQ-006 SHALL have port time_val, input, 14 bits: cycle time, decimal.
REQ-007 SHALL have port pc, input, 32 bits.
REQ-008 SHALL have port grf, input, 14 bits: register number, decimal (kind=0).
REQ-009 SHALL have port addr, input, 32 bits: memory address (kind=1).
REQ-010 SHALL have port data, input, 32 bits: written value.
REQ-011 SHALL have port char_out, output, 8 bits: ASCII character.
REQ-012 SHALL have port out_valid, output, 1 bit: char_out is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream takes char_out.
REQ-014 SHALL have port last, output, 1 bit: char_out is the terminating '#'.
REQ-015 SHALL have port clamped, output, 1 bit: current record had time_val or grf greater than 9999.

Function
REQ-016 SHALL emit kind=0 as "^" T "@" P ": $" G " <= " D "#".
REQ-017 SHALL emit kind=1 as "^" T "@" P ": *" A " <= " D "#".
REQ-018 SHALL render fields as follows:
- T, G: decimal, 1-4 digits, no leading zeros; zero renders as "0".
- P, A, D: exactly 8 lowercase hex digits, MSB first.
REQ-019 SHALL clamp time_val and grf values above 9999 to 9999, and hold clamped high from capture until the record ends.
REQ-020 SHALL drive in_ready high only in IDLE; all inputs are captured on the edge where in_valid && in_ready.
REQ-021 SHALL use states IDLE, CONV, CARET, TIME, AT, PC, COLON, SP1, TAG, FIELD, SP2, LT, EQ, SP3, DATA, HASH.
- Capture moves IDLE->CONV.
- CONV lasts exactly 14 cycles and converts T and G in parallel.
- CONV then goes to CARET.
REQ-022 SHALL raise out_valid first on the 15th cycle after the capture edge.
REQ-023 SHALL hold out_valid high continuously from CARET through HASH.
REQ-024 SHALL advance one character only on a cycle where out_valid && out_ready.
REQ-025 SHALL hold char_out stable while out_valid && !out_ready.
REQ-026 SHALL step multi-character states (TIME, PC, FIELD, DATA) with a 3-bit index.
- TIME and FIELD-decimal exit after the significant digit count.
- PC, FIELD-hex and DATA exit after index 7.
REQ-027 SHALL assert last only together with '#'; the '#' handshake returns to IDLE, and in_ready is high the next cycle.
REQ-028 SHALL produce exactly 26+t+g characters for kind=0 and 34+t for kind=1, where t and g are digit counts.
REQ-029 SHALL drive char_out to 8'h00 whenever out_valid is low.
REQ-030 SHALL ignore in_valid while not in IDLE and SHALL NOT stall or corrupt the record in flight.

Reset
REQ-031 SHALL on reset, including mid-record, go to IDLE and clear index, captured fields and converter state.
REQ-032 SHALL have these values in the cycle after reset: out_valid=0, last=0, char_out=0, clamped=0, in_ready=1.
REQ-033 SHALL make reset take priority over every handshake in the same cycle.

Structure
REQ-034 SHALL place the state encodings and character constants (^ @ : $ * < = # space) in shared header cpu_trace_defs.vh.
REQ-035 SHALL place the sequential 14-bit double-dabble converter in sub-module dec4_conv.
- Ports: clk, reset, start, bin[13:0]; outputs bcd[15:0], ndig[2:0], done.
- Instantiated twice: time and grf.

Verification
REQ-036 SHALL cover a register record:
- Stimulus: kind=0, time=5, pc=0x00003000, grf=31, data=0xdeadbeef, out_ready=1.
- Response: "^5@00003000: $31 <= deadbeef#", 29 characters, last on character 29, first character 15 cycles after accept.
REQ-037 SHALL cover a memory record:
- Stimulus: kind=1, time=1234, pc=0x00400010, addr=0x10008000, data=0.
- Response: "^1234@00400010: *10008000 <= 00000000#", 38 characters.
REQ-038 SHALL cover zero and clamp values:
- Stimulus 1: time=0, grf=0 -> "^0@...: $0 <= ...#".
- Stimulus 2: time=12000 -> T="9999" with clamped=1, and clamped=0 on the next record.
REQ-039 SHALL cover backpressure:
- Stimulus: out_ready toggles randomly.
- Response: the stream is identical to the out_ready=1 run, and char_out never changes while stalled.
REQ-040 SHALL cover reset mid-record:
- Stimulus: reset asserted during the PC field.
- Response: next cycle out_valid=0 and in_ready=1; the next record emits completely from '^'.
REQ-041 SHALL cover overlap:
- Stimulus: in_valid held high with changing inputs during emission.
- Response: the current record is unaffected and the next record is captured only in IDLE.
